mux_scan_controller: RTL and testbench

MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

---
 rtl/mux_scan_controller.sv | 110 +++++++++++
 tb/tb_mux_scan_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_controller.sv
// Sweeps a 4:1 mux through channels 0..3 and holds each for dwell+1 cycles, sampling d on each channel's last cycle.
// Publishes a 4-bit word 4*(dwell+1) cycles after start. There is no backpressure: abort cancels the sweep, continuous re-arms it.
module mux_scan_controller #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               d,
  output logic               s1,
  output logic               s0,
  output logic [3:0]         word,
  output logic               valid,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         sel, sel_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] dwell_r, dwell_r_nxt;
  logic [2:0]         shadow, shadow_nxt;
  logic [3:0]         word_nxt;
  logic               valid_nxt;

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    cnt_nxt     = cnt;
    dwell_r_nxt = dwell_r;
    shadow_nxt  = shadow;
    word_nxt    = word;
    valid_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt   = SCAN;
          sel_nxt     = 2'd0;
          cnt_nxt     = dwell;
          dwell_r_nxt = dwell;
        end
      end

      SCAN: begin
        // Abort wins over a capture that would complete on this edge.
        if (abort) begin
          state_nxt = IDLE;
          sel_nxt   = 2'd0;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (sel != 2'd3) begin
          shadow_nxt[sel] = d;
          sel_nxt         = sel + 2'd1;
          cnt_nxt         = dwell_r;
        end else begin
          word_nxt  = {d, shadow};
          valid_nxt = 1'b1;
          sel_nxt   = 2'd0;
          if (continuous) begin
            cnt_nxt = dwell_r;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        sel_nxt   = 2'd0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // busy gets its own flop so no output is decoded from state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 2'd0;
      cnt     <= '0;
      dwell_r <= '0;
      shadow  <= 3'd0;
      word    <= 4'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      cnt     <= cnt_nxt;
      dwell_r <= dwell_r_nxt;
      shadow  <= shadow_nxt;
      word    <= word_nxt;
      valid   <= valid_nxt;
      busy    <= (state_nxt == SCAN);
    end
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed and randomized sweeps against a timing/word model built from channel arithmetic.
module tb_mux_scan_controller;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          continuous;
  logic [DW-1:0] dwell;
  logic          d;
  logic          s1;
  logic          s0;
  logic [3:0]    word;
  logic          valid;
  logic          busy;
  logic [3:0]    mux_in;
  logic [3:0]    exp_word;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  // The scanned mux: channel n presents mux_in[n].
  assign d = mux_in[{s1, s0}];

  mux_scan_controller #(.DWELL_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .continuous(continuous),
    .dwell     (dwell),
    .d         (d),
    .s1        (s1),
    .s0        (s0),
    .word      (word),
    .valid     (valid),
    .busy      (busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_sel"}, 32'({s1, s0}), 0);
      check({tag, "_valid"}, 32'(valid), 0);
      check({tag, "_word"}, 32'(word), 32'(exp_word));
    end
  endtask

  // Leaves the bench just after the start edge.
  task automatic launch(input int dw);
    dwell = DW'(dw);
    start = 1'b1;
    step();
    start = 1'b0;
    dwell = DW'($urandom);
  endtask

  // Entered just after a sweep's first edge; channel index is the edge count divided by dwell+1.
  task automatic sweep(input int dw, input bit cont);
    int len;
    len = 4 * (dw + 1);
    check("entry_sel", 32'({s1, s0}), 0);
    check("entry_busy", 32'(busy), 1);
    for (int j = 1; j < len; j++) begin
      dwell      = DW'($urandom);
      start      = 1'($urandom);
      continuous = 1'($urandom);
      step();
      check("sweep_sel", 32'({s1, s0}), 32'(j / (dw + 1)));
      check("sweep_busy", 32'(busy), 1);
      check("sweep_valid", 32'(valid), 0);
    end
    start      = 1'b0;
    continuous = cont;
    step();
    exp_word   = mux_in;
    continuous = 1'b0;
    check("end_valid", 32'(valid), 1);
    check("end_word", 32'(word), 32'(exp_word));
    check("end_busy", 32'(busy), 32'(cont));
    check("end_sel", 32'({s1, s0}), 0);
  endtask

  // Abort lands on edge j_abort counted from the start edge.
  task automatic abort_at(input int dw, input int j_abort);
    mux_in = ~exp_word;
    launch(dw);
    for (int j = 1; j < j_abort; j++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_sel", 32'({s1, s0}), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_word", 32'(word), 32'(exp_word));
    idle_check("post_abort", 3);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    continuous = 1'b0;
    dwell      = '0;
    mux_in     = 4'd0;
    exp_word   = 4'd0;
    step();
    step();
    check("rst_s1", 32'(s1), 0);
    check("rst_s0", 32'(s0), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_word", 32'(word), 0);
    reset = 1'b0;
    idle_check("post_reset", 3);

    // Scenario 1: single-cycle dwell, inputs 1,0,1,1.
    mux_in = 4'b1101;
    launch(0);
    sweep(0, 1'b0);
    check("s1_word", 32'(word), 32'h0000000d);
    idle_check("s1_idle", 2);

    // Scenario 2: dwell 3, dwell input scrambled during the sweep.
    mux_in = 4'b0110;
    launch(3);
    sweep(3, 1'b0);
    check("s2_word", 32'(word), 32'h00000006);
    idle_check("s2_idle", 2);

    // Scenario 3: continuous sweeps with inputs changed between them.
    mux_in = 4'b0101;
    launch(1);
    sweep(1, 1'b1);
    mux_in = 4'b1000;
    sweep(1, 1'b1);
    check("s3_word2", 32'(word), 32'h00000008);
    mux_in = 4'b0011;
    sweep(1, 1'b0);
    idle_check("s3_idle", 2);

    // Scenario 4: abort mid-sweep at channel 2, on the capture edge, and on the first edge.
    abort_at(1, 5);
    abort_at(1, 8);
    abort_at(0, 4);
    abort_at(2, 1);

    // Scenario 5: start together with abort in IDLE is dropped.
    start = 1'b1;
    abort = 1'b1;
    dwell = DW'(2);
    step();
    start = 1'b0;
    abort = 1'b0;
    idle_check("s5_idle", 3);
    mux_in = 4'b1010;
    launch(2);
    sweep(2, 1'b0);
    idle_check("s5_after", 1);

    // Randomized chains of sweeps.
    for (int r = 0; r < 10; r++) begin
      int dw;
      int chain;
      dw     = int'($urandom_range(0, 5));
      chain  = int'($urandom_range(0, 2));
      mux_in = 4'($urandom);
      launch(dw);
      for (int k = 0; k < chain; k++) begin
        sweep(dw, 1'b1);
        mux_in = 4'($urandom);
      end
      sweep(dw, 1'b0);
      idle_check("rand_idle", 1);
    end

    // Scenario 6: asynchronous reset between edges mid-sweep.
    mux_in = 4'b1111;
    launch(1);
    sweep(1, 1'b1);
    for (int j = 1; j < 5; j++) step();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_word = 4'd0;
    check("async_s1", 32'(s1), 0);
    check("async_s0", 32'(s0), 0);
    check("async_word", 32'(word), 0);
    check("async_valid", 32'(valid), 0);
    check("async_busy", 32'(busy), 0);
    step();
    reset = 1'b0;
    idle_check("post_async", 4);
    mux_in = 4'b0001;
    launch(0);
    sweep(0, 1'b0);
    idle_check("final_idle", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
